// File: rtl/ctrl_decode_if.sv
// Decode-to-execute control bundle: instruction slot in, registered controls out.
// The slave side belongs to the decode stage, the master side to whoever drives it.
interface ctrl_decode_if #(
    parameter int RW     = 4,
    parameter int ALUOPW = 2
);
    logic              in_valid;
    logic [3:0]        in_opcode;
    logic [RW-1:0]     in_rs;
    logic [RW-1:0]     in_rt;
    logic [RW-1:0]     in_rd;
    logic              in_ready;
    logic              ex_stall;
    logic              flush;
    logic              out_valid;
    logic              r15;
    logic              alu_src;
    logic              mem_to_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic [ALUOPW-1:0] alu_op;
    logic [RW-1:0]     out_rd;
    logic              illegal;

    modport slave (
        input  in_valid, in_opcode, in_rs, in_rt, in_rd,
        input  ex_stall, flush,
        output in_ready, out_valid, r15, alu_src, mem_to_reg,
        output reg_write, mem_read, mem_write, branch,
        output alu_op, out_rd, illegal
    );

    modport master (
        output in_valid, in_opcode, in_rs, in_rt, in_rd,
        output ex_stall, flush,
        input  in_ready, out_valid, r15, alu_src, mem_to_reg,
        input  reg_write, mem_read, mem_write, branch,
        input  alu_op, out_rd, illegal
    );
endinterface

// File: rtl/ctrl_decode_stage.sv
// Registered control decoder with valid/stall/flush handling and a
// load-use interlock that inserts LD_BUBBLES bubbles.
module ctrl_decode_stage #(
    parameter int RW         = 4,
    parameter int LD_BUBBLES = 1,
    parameter int ALUOPW     = 2
) (
    input logic           clk,
    input logic           rst,
    ctrl_decode_if.slave  bus
);
    localparam logic [2:0] RELOAD =
        (LD_BUBBLES > 0) ? 3'(LD_BUBBLES - 1) : 3'd0;

    // {r15, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch}
    logic [6:0]        dec_ctrl;
    logic [1:0]        dec_aop;
    logic              dec_known;

    logic [2:0]        cnt;
    logic [6:0]        ctrl_q;
    logic [ALUOPW-1:0] aop_q;
    logic [RW-1:0]     rd_q;
    logic              valid_q;
    logic              ill_q;

    logic              hazard;
    logic              ready;
    logic              accept;

    logic [2:0]        n_cnt;
    logic [6:0]        n_ctrl;
    logic [ALUOPW-1:0] n_aop;
    logic [RW-1:0]     n_rd;
    logic              n_valid;
    logic              n_ill;

    always_comb begin
        dec_ctrl  = 7'b0000000;
        dec_aop   = 2'b00;
        dec_known = 1'b1;
        unique case (bus.in_opcode)
            4'hF:             begin dec_ctrl = 7'b0001000; dec_aop = 2'b11; end
            4'h8:             begin dec_ctrl = 7'b0101000; dec_aop = 2'b11; end
            4'h9:             begin dec_ctrl = 7'b0101000; dec_aop = 2'b10; end
            4'hA, 4'hC:       dec_ctrl = 7'b0111100;
            4'hB, 4'hD:       dec_ctrl = 7'b0100010;
            4'h4, 4'h5, 4'h6: begin dec_ctrl = 7'b1000001; dec_aop = 2'b01; end
            4'h1:             dec_ctrl = 7'b0000001;
            4'h0:             dec_ctrl = 7'b0000000;
            default:          dec_known = 1'b0;
        endcase
    end

    // Load in flight whose destination feeds the waiting instruction.
    always_comb begin
        hazard = 1'b0;
        if (LD_BUBBLES > 0)
            hazard = valid_q && ctrl_q[2] && (rd_q != '0) &&
                     bus.in_valid &&
                     ((bus.in_rs == rd_q) || (bus.in_rt == rd_q));
    end

    assign ready  = !rst && !bus.flush && !bus.ex_stall &&
                    (cnt == 3'd0) && !hazard;
    assign accept = bus.in_valid && ready;

    always_comb begin
        n_cnt   = 3'd0;
        n_ctrl  = 7'b0000000;
        n_aop   = '0;
        n_rd    = '0;
        n_valid = 1'b0;
        n_ill   = 1'b0;
        if (cnt != 3'd0) begin
            n_cnt = cnt - 3'd1;
        end else if (hazard) begin
            n_cnt = RELOAD;
        end else if (accept) begin
            if (dec_known) begin
                n_valid = 1'b1;
                n_ctrl  = dec_ctrl;
                n_aop   = ALUOPW'(dec_aop);
                n_rd    = dec_ctrl[3] ? bus.in_rd : '0;
            end else begin
                n_ill = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            cnt     <= 3'd0;
            ctrl_q  <= 7'b0000000;
            aop_q   <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
            ill_q   <= 1'b0;
        end else if (bus.ex_stall) begin
            ill_q   <= 1'b0;
        end else begin
            cnt     <= n_cnt;
            ctrl_q  <= n_ctrl;
            aop_q   <= n_aop;
            rd_q    <= n_rd;
            valid_q <= n_valid;
            ill_q   <= n_ill;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = valid_q;
    assign bus.r15        = ctrl_q[6];
    assign bus.alu_src    = ctrl_q[5];
    assign bus.mem_to_reg = ctrl_q[4];
    assign bus.reg_write  = ctrl_q[3];
    assign bus.mem_read   = ctrl_q[2];
    assign bus.mem_write  = ctrl_q[1];
    assign bus.branch     = ctrl_q[0];
    assign bus.alu_op     = aop_q;
    assign bus.out_rd     = rd_q;
    assign bus.illegal    = ill_q;
endmodule
